// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         HDR_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    RUN    = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader_boot_word_packer.sv
// Packs a big-endian byte stream into 32-bit words and flags each completed word.
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        word_done
);

  logic [1:0] byte_cnt;

  // The byte being accepted now completes a word.
  assign word_done = byte_valid && (byte_cnt == 2'd3);

  // Shift bytes in MSB-first; word_ready pulses the cycle after the 4th byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= word_done && !clear;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (byte_valid) begin
        word     <= {word[23:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed program image, writes it into instruction memory and
// holds the core in reset until a frame with a good checksum has been loaded.
module imem_boot_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = imem_boot_loader_pkg::SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  import imem_boot_loader_pkg::*;

  localparam int             MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [HDR_W:0] MAX_N     = (HDR_W + 1)'(MAX_WORDS);

  state_t              state;
  logic [7:0]          cnt_hi;
  logic [HDR_W-1:0]    n_words;
  logic [HDR_W-1:0]    n_full;
  logic [7:0]          csum;
  logic [ADDR_WIDTH:0] word_idx;
  logic                transfer;
  logic                sync_hit;
  logic                data_byte;
  logic                word_done;

  assign rx_ready  = (state != RUN);
  assign transfer  = rx_valid && rx_ready;
  assign sync_hit  = transfer && (state == IDLE) && (rx_data == SYNC_BYTE);
  assign data_byte = transfer && (state == DATA);
  assign n_full    = {cnt_hi, rx_data};
  // The write address is the count of words already written in this frame.
  assign imem_addr = words_loaded[ADDR_WIDTH-1:0];

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (sync_hit),
    .byte_valid (data_byte),
    .byte_in    (rx_data),
    .word       (imem_wdata),
    .word_ready (imem_we),
    .word_done  (word_done)
  );

  // Frame parser, checksum, word counting and core reset control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt_hi       <= 8'd0;
      n_words      <= '0;
      csum         <= 8'd0;
      word_idx     <= '0;
      words_loaded <= '0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      if (imem_we)
        words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
      case (state)
        IDLE: begin
          if (sync_hit) begin
            state        <= CNT_HI;
            load_error   <= 1'b0;
            words_loaded <= '0;
            csum         <= 8'd0;
            word_idx     <= '0;
          end
        end
        CNT_HI: begin
          if (transfer) begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (transfer) begin
            n_words <= n_full;
            if ({1'b0, n_full} > MAX_N) begin
              load_error <= 1'b1;
              state      <= IDLE;
            end else if (n_full == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (transfer) begin
            csum <= csum ^ rx_data;
            if (word_done) begin
              word_idx <= word_idx + (ADDR_WIDTH + 1)'(1);
              if (HDR_W'(word_idx) + HDR_W'(1) == n_words)
                state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (transfer) begin
            if (rx_data == csum) begin
              state      <= RUN;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        RUN: begin
          if (reload) begin
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
